// File: rtl/puf_challenge_host.sv
// Host-side sequencer for the ring-oscillator PUF: issues a run of consecutive
// challenges, waits for each response with a timeout, and streams responses out.
module puf_challenge_host #(
  parameter int CW      = 8,
  parameter int RW      = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] challenge_base,
  input  logic [3:0]    count,
  output logic [CW-1:0] puf_challenge,
  output logic          puf_start,
  input  logic          puf_done,
  input  logic [RW-1:0] puf_response,
  output logic [RW-1:0] resp_data,
  output logic [3:0]    resp_index,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic          busy,
  output logic          done,
  output logic          timeout_err,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
    S_FIN     = 3'd4
  } state_t;

  localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_chal;
  logic [3:0]    r_count;
  logic [3:0]    r_idx;
  logic [15:0]   r_timer;
  logic [RW-1:0] r_data;
  logic [3:0]    r_index;
  logic          r_terr;
  logic          w_timeout;
  logic          w_last;

  // The timer counts completed WAIT cycles; the final WAIT edge is the timeout edge.
  assign w_timeout = (r_timer == TLAST);
  assign w_last    = (4'(r_idx + 4'd1) == r_count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Response stream: a transfer happens on an edge where resp_valid and
  // resp_ready are both high; resp_data/resp_index hold until that edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = (count != 4'd0) ? S_ISSUE : S_FIN;
      S_ISSUE:   w_next = S_WAIT;
      S_WAIT: begin
        if (puf_done)       w_next = S_PRESENT;
        else if (w_timeout) w_next = S_FIN;
      end
      S_PRESENT: if (resp_ready) w_next = w_last ? S_FIN : S_ISSUE;
      S_FIN:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state != S_IDLE);
    puf_start  = (r_state == S_ISSUE);
    resp_valid = (r_state == S_PRESENT);
    done       = (r_state == S_FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chal  <= '0;
      r_count <= '0;
      r_idx   <= '0;
      r_timer <= '0;
      r_data  <= '0;
      r_index <= '0;
      r_terr  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_chal  <= challenge_base;
            r_count <= count;
            r_idx   <= '0;
            r_terr  <= 1'b0;
          end
        end
        S_ISSUE: r_timer <= '0;
        S_WAIT: begin
          r_timer <= r_timer + 16'd1;
          if (puf_done) begin
            r_data  <= puf_response;
            r_index <= r_idx;
          end else if (w_timeout) begin
            r_terr <= 1'b1;
          end
        end
        S_PRESENT: begin
          if (resp_ready) begin
            r_idx <= r_idx + 4'd1;
            // r_chal tracks base+idx; the CW-bit add wraps naturally.
            if (!w_last) r_chal <= r_chal + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign puf_challenge = r_chal;
  assign resp_data     = r_data;
  assign resp_index    = r_index;
  assign timeout_err   = r_terr;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_puf_challenge_host.sv
// Bench for puf_challenge_host: a table of runs against a behavioural PUF, plus
// hand-written back-pressure and mid-WAIT reset sequences.
module tb_puf_challenge_host;

  localparam int CW = 8;
  localparam int RW = 8;
  localparam int TO = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [CW-1:0] challenge_base;
  logic [3:0]    count;
  logic [CW-1:0] puf_challenge;
  logic          puf_start;
  logic          puf_done;
  logic [RW-1:0] puf_response;
  logic [RW-1:0] resp_data;
  logic [3:0]    resp_index;
  logic          resp_valid;
  logic          resp_ready;
  logic          busy;
  logic          done;
  logic          timeout_err;
  logic [2:0]    dbg_state;

  puf_challenge_host #(.CW(CW), .RW(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .challenge_base(challenge_base),
    .count(count), .puf_challenge(puf_challenge), .puf_start(puf_start),
    .puf_done(puf_done), .puf_response(puf_response), .resp_data(resp_data),
    .resp_index(resp_index), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .busy(busy), .done(done), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int errors = 0;
  int checks = 0;

  logic [RW+3:0] exp_q[$];
  logic [CW-1:0] exp_chal_q[$];

  int          puf_lat;
  bit          inj;
  bit          pend;
  int          pcnt;
  logic [CW-1:0] pchal;
  int          cyc;
  int          period;
  int          n_starts;
  int          n_resps;
  int          done_seen;
  int          done_cyc;

  typedef struct {
    logic [7:0] base;
    logic [3:0] cnt;
    int         lat;
    bit         inj;
    int         exp_done;
    int         exp_resps;
    bit         exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected by scoreboard", name);
  endtask

  // One clock cycle: monitor the current cycle, update the PUF model, advance.
  task automatic cycle_step();
    if (puf_start) begin
      if (exp_chal_q.size() == 0) fail_now("puf_start_unexpected");
      else check("puf_challenge", 32'(puf_challenge), 32'(exp_chal_q.pop_front()));
      if (period > 0) check("puf_start_cycle", cyc, 1 + n_starts * period);
      n_starts++;
    end
    if (resp_valid && resp_ready) begin
      if (exp_q.size() == 0) fail_now("resp_unexpected");
      else check("resp_index_data", 32'({resp_index, resp_data}), 32'(exp_q.pop_front()));
      n_resps++;
    end
    if (done) begin
      done_seen++;
      done_cyc = cyc;
    end
    if (puf_start) begin
      pend = 1'b1;
      pcnt = 0;
      pchal = puf_challenge;
      puf_done = inj;
      puf_response = inj ? 8'hEE : 8'h00;
    end else if (pend && puf_lat > 0) begin
      pcnt++;
      if (pcnt == puf_lat) begin
        puf_done = 1'b1;
        puf_response = pchal ^ 8'hA5;
        pend = 1'b0;
      end else begin
        puf_done = 1'b0;
      end
    end else begin
      puf_done = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic begin_run(input logic [7:0] base, input logic [3:0] cnt);
    n_starts = 0;
    n_resps = 0;
    done_seen = 0;
    done_cyc = -1;
    cyc = 0;
    start = 1'b1;
    challenge_base = base;
    count = cnt;
    cycle_step();
    start = 1'b0;
    challenge_base = 8'($urandom_range(0, 255));
    count = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_done();
    for (int t = 0; t < 300 && done_seen == 0; t++) cycle_step();
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] c;
    int n_iss;
    n_iss = (v.cnt == 0) ? 0 : (v.exp_err ? 1 : int'(v.cnt));
    for (int i = 0; i < n_iss; i++) begin
      c = v.base + 8'(i);
      exp_chal_q.push_back(c);
    end
    for (int i = 0; i < v.exp_resps; i++) begin
      c = v.base + 8'(i);
      exp_q.push_back({4'(i), c ^ 8'hA5});
    end
    puf_lat = v.lat;
    inj = v.inj;
    period = v.lat + 2;
    resp_ready = 1'b1;
    begin_run(v.base, v.cnt);
    check("busy_cycle1", busy, 1);
    check("terr_cleared_cycle1", timeout_err, 0);
    wait_done();
    check("done_cycle", done_cyc, v.exp_done);
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done, 0);
    check("timeout_err", timeout_err, v.exp_err);
    check("resp_count", n_resps, v.exp_resps);
    check("puf_start_count", n_starts, n_iss);
    check("exp_q_empty", exp_q.size(), 0);
    cycle_step();
    check("done_once", done_seen, 1);
    check("terr_idle", timeout_err, v.exp_err);
    inj = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h3C, 4'd3,  6, 1'b0, 25,  3, 1'b0};
    vecs[1] = '{8'hFE, 4'd3,  2, 1'b0, 13,  3, 1'b0};
    vecs[2] = '{8'h55, 4'd1,  1, 1'b0,  4,  1, 1'b0};
    vecs[3] = '{8'h10, 4'd0,  0, 1'b0,  1,  0, 1'b0};
    vecs[4] = '{8'h20, 4'd2,  0, 1'b0, 18,  0, 1'b1};
    vecs[5] = '{8'h80, 4'd2, 16, 1'b0, 37,  2, 1'b0};
    vecs[6] = '{8'h33, 4'd1,  4, 1'b1,  7,  1, 1'b0};
    vecs[7] = '{8'hA0, 4'd15, 3, 1'b0, 76, 15, 1'b0};
    vecs[8] = '{8'hFF, 4'd2,  5, 1'b0, 15,  2, 1'b0};
    vecs[9] = '{8'h21, 4'd1, 17, 1'b0, 18,  0, 1'b1};

    rst = 1'b1;
    start = 1'b0;
    challenge_base = '0;
    count = '0;
    puf_done = 1'b0;
    puf_response = '0;
    resp_ready = 1'b0;
    puf_lat = 0;
    inj = 1'b0;
    pend = 1'b0;
    pcnt = 0;
    pchal = '0;
    period = 0;
    cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {puf_challenge, puf_start, resp_data, resp_index, resp_valid,
                            busy, done, timeout_err}, 0);
    check("reset_state", dbg_state, 0);
    rst = 1'b0;
    cycle_step();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-pressure, with a start pulse while busy that must be ignored.
    exp_chal_q.push_back(8'h40);
    exp_chal_q.push_back(8'h41);
    exp_q.push_back({4'd0, 8'hE5});
    exp_q.push_back({4'd1, 8'hE4});
    puf_lat = 3;
    period = 0;
    resp_ready = 1'b0;
    begin_run(8'h40, 4'd2);
    for (int t = 0; t < 20 && !resp_valid; t++) cycle_step();
    check("bp_resp_valid", resp_valid, 1);
    for (int k = 0; k < 7; k++) begin
      check("bp_hold_data", resp_data, 8'hE5);
      check("bp_hold_index", resp_index, 0);
      check("bp_no_puf_start", puf_start, 0);
      if (k == 2) begin
        start = 1'b1;
        challenge_base = 8'h99;
        count = 4'd5;
      end
      cycle_step();
      start = 1'b0;
    end
    resp_ready = 1'b1;
    wait_done();
    check("bp_done_seen", done_seen, 1);
    check("bp_starts", n_starts, 2);
    check("bp_resps", n_resps, 2);
    check("bp_exp_q_empty", exp_q.size(), 0);
    cycle_step();

    // Asynchronous reset in the middle of WAIT.
    exp_chal_q.push_back(8'h70);
    puf_lat = 0;
    period = 0;
    begin_run(8'h70, 4'd2);
    cycle_step();
    cycle_step();
    check("pre_reset_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {puf_challenge, puf_start, resp_data, resp_index, resp_valid,
                                  busy, done, timeout_err}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pend = 1'b0;
    puf_done = 1'b0;
    exp_q.delete();
    exp_chal_q.delete();
    run_vec('{8'h10, 4'd1, 4, 1'b0, 7, 1, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/puf_challenge_host.md
# puf_challenge_host

Host-side challenge/response sequencer for the ring-oscillator PUF core: the initiator end of the challenge/response interface that the `tt_um_PUF` top exposes on its dedicated pins. On a start command it issues a run of consecutive challenges to the PUF, waits for each response with a timeout, and presents each response on a valid/ready stream to downstream logic (readout/serializer). It sits between the PUF core and the output path inside the user project.

## Interface
Parameters:
- `CW`, 8: challenge width.
- `RW`, 8: response width.
- `TIMEOUT`, 1023: maximum cycles spent waiting for `puf_done` per challenge; legal range 1..65535.

Ports:
- `clk`  in  1  single clock; all state on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `challenge_base`  in  CW  first challenge of the run; latched on accepted `start`.
- `count`  in  4  number of challenges in the run; latched on accepted `start`.
- `puf_challenge`  out  CW  challenge driven to PUF core.
- `puf_start`  out  1  one-cycle pulse requesting an evaluation.
- `puf_done`  in  1  PUF evaluation complete; `puf_response` valid while high.
- `puf_response`  in  RW  PUF response.
- `resp_data`  out  RW  captured response.
- `resp_index`  out  4  index (0-based) of the challenge within the run.
- `resp_valid`  out  1  `resp_data`/`resp_index` valid.
- `resp_ready`  in  1  downstream accepts.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at end of run (normal or aborted).
- `timeout_err`  out  1  sticky: a run was aborted by timeout.

## Operation
- States: IDLE, ISSUE, WAIT, PRESENT, FIN.
- IDLE: `start`=1 latches `challenge_base`, `count`; clears `idx` and `timeout_err`. `count`≠0 → ISSUE; `count`=0 → FIN (no PUF activity). `start` outside IDLE ignored.
- ISSUE (1 cycle): `puf_challenge` = (base + idx) mod 2^CW (wraps, e.g. 0xFF+1 → 0x00); `puf_start`=1; timer cleared; → WAIT.
- WAIT: `puf_challenge` held; timer increments each cycle. `puf_done`=1 → capture `puf_response` into `resp_data`, `idx` into `resp_index`; → PRESENT. Timer reaching TIMEOUT with `puf_done`=0 → set `timeout_err`; → FIN. `puf_done` and timeout on the same edge: `puf_done` wins.
- `puf_done` outside WAIT (including the ISSUE cycle) is ignored.
- PRESENT: `resp_valid`=1; `resp_data`/`resp_index` stable until handshake (`resp_valid`&`resp_ready` at an edge). On handshake `idx`++; idx==count → FIN, else → ISSUE.
- FIN (1 cycle): `done`=1; → IDLE.
- Reset (any state, asynchronous): state IDLE; all outputs 0 (`puf_challenge`, `puf_start`, `resp_data`, `resp_index`, `resp_valid`, `busy`, `done`, `timeout_err`); timer, `idx`, latched base/count cleared. In-flight response is discarded.
- `timeout_err` persists through IDLE until the next accepted `start` or reset.

## Timing
- `start` sampled at edge 0 → ISSUE in cycle 1 (`puf_start` high cycle 1 only), WAIT from cycle 2.
- `puf_done` high at edge k → `resp_valid` high from cycle k+1.
- Handshake at edge m → next `puf_start` in cycle m+1; for the last challenge, `done` in cycle m+1, `busy` low from cycle m+2.
- `resp_ready` held high with `puf_done` returned after d cycles: one response per d+3 cycles.
- Timeout: `puf_done` never asserted → `timeout_err` and `done` rise TIMEOUT cycles after WAIT entry; `busy` low one cycle later.
- `count`=0: `done` in cycle 1, `busy` high cycle 1 only.
- `puf_start` is never high while `busy` was low in the previous cycle except in ISSUE.

## Test plan
- Reset: assert `rst` mid-WAIT → all outputs 0 immediately (before next edge); after release, `start` with base 0x10, count 1 runs normally.
- Normal run: base 0x3C, count 3, PUF model returns challenge XOR 0xA5 after 5 cycles, `resp_ready`=1 → responses 0x99,0x98,0x9B with indices 0,1,2; `puf_start` at cycles 1, 9, 17; `done` once; `timeout_err`=0.
- Back-pressure: count 2, `resp_ready` low 7 cycles after first `resp_valid` → `resp_data`/`resp_index` stable, no second `puf_start` until handshake.
- Wrap: base 0xFE, count 3 → `puf_challenge` 0xFE, 0xFF, 0x00.
- Timeout: TIMEOUT=16, `puf_done` never → `timeout_err`=1 and `done` 16 cycles after WAIT entry, no `resp_valid`; next `start` clears `timeout_err`; `puf_done` on the exact timeout edge → response accepted, no error.
- Edge cases: count 0 → `done` cycle 1, no `puf_start`; `start` during busy ignored; `puf_done` during ISSUE ignored.
